// File: rtl/encoder_pkg.sv
`default_nettype none
// encoder_pkg: shared state encoding, widths and popcount helper for encoder16to4_seq.
// Revision 1.0
package encoder_pkg;

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam int N_LINES = 16;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 5;

  function automatic logic [CNT_W-1:0] popcount(input logic [N_LINES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_LINES; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prio_find16.sv
`default_nettype none
// prio_find16: combinational set-bit finder; idx is the lowest (or highest) set bit of vec.
// Revision 1.0
module prio_find16
  import encoder_pkg::*;
(
  input  logic [N_LINES-1:0] vec,
  input  logic               msb_first,
  output logic [IDX_W-1:0]   idx,
  output logic               one_left
);

  // Later matches overwrite earlier ones, so the scan direction picks the winner.
  always_comb begin
    idx = '0;
    if (msb_first) begin
      for (int i = 0; i < N_LINES; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = N_LINES - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end

  assign one_left = (vec != '0) && ((vec & (vec - N_LINES'(1))) == '0);

endmodule
`default_nettype wire

// File: rtl/encoder16to4_seq.sv
`default_nettype none
// encoder16to4_seq: serialises a multi-hot 16-bit vector into one 4-bit index beat per set bit.
// Revision 1.0
module encoder16to4_seq
  import encoder_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_LINES-1:0] D,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   A,
  output logic               last,
  output logic               zero,
  output logic [CNT_W-1:0]   cnt
);

  state_t             state, state_nxt;
  logic [N_LINES-1:0] pend;
  logic [N_LINES-1:0] pend_clr;
  logic [N_LINES-1:0] find_vec;
  logic [IDX_W-1:0]   find_idx;
  logic               find_one;
  logic               msb_first;
  logic               accept;
  logic               beat_done;

  assign msb_first = (LSB_FIRST == 0);
  assign in_ready  = rst_n && enable && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign beat_done = out_valid && out_ready;
  assign pend_clr  = pend & ~(N_LINES'(1) << A);

  // One finder serves both the incoming vector and the post-beat remainder.
  assign find_vec  = (state == IDLE) ? D : pend_clr;

  prio_find16 u_find (
    .vec       (find_vec),
    .msb_first (msb_first),
    .idx       (find_idx),
    .one_left  (find_one)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SCAN;
      SCAN:    if (beat_done && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend      <= '0;
      out_valid <= 1'b0;
      A         <= '0;
      last      <= 1'b0;
      zero      <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      pend      <= D;
      cnt       <= popcount(D);
      zero      <= (D == '0);
      A         <= find_idx;
      last      <= find_one || (D == '0);
      out_valid <= 1'b1;
    end else if (beat_done) begin
      pend <= pend_clr;
      if (last) begin
        out_valid <= 1'b0;
      end else begin
        A    <= find_idx;
        last <= find_one;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_encoder16to4_seq.sv
`default_nettype none
// tb_encoder16to4_seq: directed self-checking bench for encoder16to4_seq (both scan orders).
// Revision 1.0
module tb_encoder16to4_seq;

  logic        clk = 1'b0;
  logic        rst_n, enable, in_valid, out_ready;
  logic [15:0] D;
  logic        in_ready_l, out_valid_l, last_l, zero_l;
  logic [3:0]  a_l;
  logic [4:0]  cnt_l;
  logic        in_ready_m, out_valid_m, last_m, zero_m;
  logic [3:0]  a_m;
  logic [4:0]  cnt_m;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  encoder16to4_seq #(.LSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready_l),
    .D(D), .out_valid(out_valid_l), .out_ready(out_ready), .A(a_l), .last(last_l),
    .zero(zero_l), .cnt(cnt_l)
  );

  encoder16to4_seq #(.LSB_FIRST(0)) dut_m (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready_m),
    .D(D), .out_valid(out_valid_m), .out_ready(out_ready), .A(a_m), .last(last_m),
    .zero(zero_m), .cnt(cnt_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat word = {out_valid, A, last, zero, cnt}
  task automatic beat_l(input string tag, input logic v, input logic [3:0] a,
                        input logic l, input logic z, input logic [4:0] c);
    chk(tag, {20'd0, out_valid_l, a_l, last_l, zero_l, cnt_l}, {20'd0, v, a, l, z, c});
  endtask

  task automatic beat_m(input string tag, input logic v, input logic [3:0] a,
                        input logic l, input logic z, input logic [4:0] c);
    chk(tag, {20'd0, out_valid_m, a_m, last_m, zero_m, cnt_m}, {20'd0, v, a, l, z, c});
  endtask

  // Present d for one edge while IDLE; returns at the negedge where the first beat shows.
  task automatic send(input logic [15:0] d);
    D = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [3:0] exp_l [4];
  logic [3:0] exp_m [4];

  initial begin
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b1; D = 16'h0;
    @(negedge clk); @(negedge clk);
    beat_l("reset_outputs", 1'b0, 4'd0, 1'b0, 1'b0, 5'd0);
    chk("reset_in_ready", {31'd0, in_ready_l}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // enable low blocks acceptance
    D = 16'h0001; in_valid = 1'b1; #1;
    chk("disabled_in_ready", {31'd0, in_ready_l}, 32'd0);
    @(negedge clk);
    chk("disabled_no_beat", {31'd0, out_valid_l}, 32'd0);
    in_valid = 1'b0;

    // single-bit vector
    enable = 1'b1; #1;
    chk("idle_in_ready", {31'd0, in_ready_l}, 32'd1);
    send(16'h0001);
    beat_l("v0001", 1'b1, 4'd0, 1'b1, 1'b0, 5'd1);
    chk("scan_in_ready", {31'd0, in_ready_l}, 32'd0);
    @(negedge clk);
    beat_l("v0001_done", 1'b0, 4'd0, 1'b1, 1'b0, 5'd1);
    chk("back_idle_ready", {31'd0, in_ready_l}, 32'd1);

    // 8421 in both scan orders, back-to-back beats
    exp_l = '{4'd0, 4'd5, 4'd10, 4'd15};
    exp_m = '{4'd15, 4'd10, 4'd5, 4'd0};
    send(16'h8421);
    for (int i = 0; i < 4; i++) begin
      beat_l($sformatf("v8421_lsb_%0d", i), 1'b1, exp_l[i], (i == 3), 1'b0, 5'd4);
      beat_m($sformatf("v8421_msb_%0d", i), 1'b1, exp_m[i], (i == 3), 1'b0, 5'd4);
      @(negedge clk);
    end
    chk("v8421_end", {30'd0, out_valid_l, out_valid_m}, 32'd0);

    // zero vector
    send(16'h0000);
    beat_l("v0000", 1'b1, 4'd0, 1'b1, 1'b1, 5'd0);
    @(negedge clk);
    chk("v0000_end", {31'd0, out_valid_l}, 32'd0);

    // backpressure holds the beat
    out_ready = 1'b0;
    send(16'h0300);
    for (int i = 0; i < 3; i++) begin
      beat_l($sformatf("v0300_stall_%0d", i), 1'b1, 4'd8, 1'b0, 1'b0, 5'd2);
      if (i < 2) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    beat_l("v0300_second", 1'b1, 4'd9, 1'b1, 1'b0, 5'd2);
    @(negedge clk);

    // full vector: 16 beats in order
    send(16'hFFFF);
    for (int i = 0; i < 16; i++) begin
      beat_l($sformatf("vffff_%0d", i), 1'b1, 4'(i), (i == 15), 1'b0, 5'd16);
      @(negedge clk);
    end
    chk("vffff_end", {31'd0, out_valid_l}, 32'd0);

    // enable dropped mid-scan
    send(16'h8421);
    beat_l("en_drop_0", 1'b1, 4'd0, 1'b0, 1'b0, 5'd4);
    enable = 1'b0;
    @(negedge clk);
    beat_l("en_drop_1", 1'b1, 4'd5, 1'b0, 1'b0, 5'd4);
    @(negedge clk);
    beat_l("en_drop_2", 1'b1, 4'd10, 1'b0, 1'b0, 5'd4);
    @(negedge clk);
    beat_l("en_drop_3", 1'b1, 4'd15, 1'b1, 1'b0, 5'd4);
    @(negedge clk);
    chk("en_drop_end", {31'd0, out_valid_l}, 32'd0);
    enable = 1'b1;

    // new vector offered during the last beat waits for IDLE
    send(16'h0003);
    beat_l("v0003_0", 1'b1, 4'd0, 1'b0, 1'b0, 5'd2);
    @(negedge clk);
    beat_l("v0003_1", 1'b1, 4'd1, 1'b1, 1'b0, 5'd2);
    D = 16'h0004; in_valid = 1'b1;
    @(negedge clk);
    chk("overlap_idle_gap", {30'd0, out_valid_l, in_ready_l}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    beat_l("overlap_accept", 1'b1, 4'd2, 1'b1, 1'b0, 5'd1);
    @(negedge clk);

    // reset mid-scan
    send(16'hFFFF);
    for (int i = 0; i < 5; i++) @(negedge clk);
    beat_l("rst_mid_pre", 1'b1, 4'd5, 1'b0, 1'b0, 5'd16);
    rst_n = 1'b0;
    @(negedge clk);
    beat_l("rst_mid_outputs", 1'b0, 4'd0, 1'b0, 1'b0, 5'd0);
    beat_m("rst_mid_outputs_m", 1'b0, 4'd0, 1'b0, 1'b0, 5'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready_l}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'h0010);
    beat_l("post_rst", 1'b1, 4'd4, 1'b1, 1'b0, 5'd1);
    beat_m("post_rst_m", 1'b1, 4'd4, 1'b1, 1'b0, 5'd1);
    @(negedge clk);
    chk("post_rst_end", {31'd0, out_valid_l}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
